// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder: wait-state data-memory responder with byte-masked stores,
// a valid/ready request port and a held valid/ready response port.  Rev 1.0
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [3:0]  count;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          src_we;
  logic [31:0]   src_addr;
  logic [31:0]   src_wdata;
  logic [3:0]    src_be;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          mem_write;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // With zero wait states the response is formed on the accept edge, so the
  // request is taken straight from the ports instead of the latched copy.
  always_comb begin
    accept     = (state == IDLE) && req_valid;
    enter_resp = (accept && (WAIT_INIT == 4'd0)) ||
                 ((state == WAIT) && (count == 4'd1));
    src_we     = (state == IDLE) ? req_we    : we_q;
    src_addr   = (state == IDLE) ? req_addr  : addr_q;
    src_wdata  = (state == IDLE) ? req_wdata : wdata_q;
    src_be     = (state == IDLE) ? req_be    : be_q;
    err        = (src_addr[1:0] != 2'b00) ||
                 ({2'b00, src_addr[31:2]} >= 32'(DEPTH_WORDS));
    idx        = src_addr[AW+1:2];
    old_word   = mem[idx];
    merged     = old_word;
    for (int i = 0; i < 4; i++) begin
      if (src_be[i]) merged[8*i +: 8] = src_wdata[8*i +: 8];
    end
    mem_write  = enter_resp && !err && src_we && !reset;
  end

  // Array has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_write) mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            count   <= WAIT_INIT;
            state   <= (WAIT_INIT == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= err ? 32'd0 : (src_we ? merged : old_word);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// tb_dmem_responder: directed vector table plus multi-cycle corner sequences
// on a WAIT_CYCLES=2 instance (index 1) and a WAIT_CYCLES=0 instance (index 0).
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid_s  [2];
  logic        req_ready_s  [2];
  logic        req_we_s     [2];
  logic [31:0] req_addr_s   [2];
  logic [31:0] req_wdata_s  [2];
  logic [3:0]  req_be_s     [2];
  logic        resp_valid_s [2];
  logic        resp_ready_s [2];
  logic [31:0] resp_rdata_s [2];
  logic        resp_err_s   [2];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_we(req_we_s[0]),
    .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]), .req_be(req_be_s[0]),
    .resp_valid(resp_valid_s[0]), .resp_ready(resp_ready_s[0]),
    .resp_rdata(resp_rdata_s[0]), .resp_err(resp_err_s[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_we(req_we_s[1]),
    .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]), .req_be(req_be_s[1]),
    .resp_valid(resp_valid_s[1]), .resp_ready(resp_ready_s[1]),
    .resp_rdata(resp_rdata_s[1]), .resp_err(resp_err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction with resp_ready high; checks ready, latency, data, err.
  task automatic txn(input int s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    check({nm, " req_ready"}, 32'(req_ready_s[s]), 32'd1);
    req_valid_s[s] = 1'b1;
    req_we_s[s]    = we;
    req_addr_s[s]  = addr;
    req_wdata_s[s] = wdata;
    req_be_s[s]    = be;
    resp_ready_s[s] = 1'b1;
    @(posedge clk); #1;
    req_valid_s[s] = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp_valid_s[s]) break;
    end
    check({nm, " latency"}, 32'(lat), (s == 1) ? 32'd3 : 32'd1);
    check({nm, " rdata"}, resp_rdata_s[s], exp_rd);
    check({nm, " err"}, 32'(resp_err_s[s]), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t v[14];

  initial begin
    int lat;
    int k;
    int nresp;
    logic was_ready;
    logic [31:0] exp0 [4];
    int resp_cyc [4];

    v[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
    v[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h11223344, 1'b0};
    v[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h11BB33DD, 1'b0};
    v[4]  = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
    v[5]  = '{1'b0, 32'h22,  32'h0,        4'hF, 32'h0,        1'b1};
    v[6]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0};
    v[7]  = '{1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    v[8]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    v[9]  = '{1'b1, 32'h13,  32'h00000000, 4'hF, 32'h0,        1'b1};
    v[10] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    v[11] = '{1'b1, 32'h24,  32'h0BADF00D, 4'hF, 32'h0BADF00D, 1'b0};
    v[12] = '{1'b1, 32'h24,  32'hFFFFFFFF, 4'h0, 32'h0BADF00D, 1'b0};
    v[13] = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'hFFFFFFFF, 1'b0};  // last word
    // v[13] depends on a prior store to the last word, done just before the loop

    for (int s = 0; s < 2; s++) begin
      req_valid_s[s] = 1'b0; req_we_s[s] = 1'b0; req_addr_s[s] = 32'd0;
      req_wdata_s[s] = 32'd0; req_be_s[s] = 4'd0; resp_ready_s[s] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready",  32'(req_ready_s[1]),  32'd1);
    check("rst resp_valid", 32'(resp_valid_s[1]), 32'd0);
    check("rst rdata",      resp_rdata_s[1],      32'd0);
    check("rst err",        32'(resp_err_s[1]),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post-rst req_ready",  32'(req_ready_s[1]),  32'd1);
    check("post-rst resp_valid", 32'(resp_valid_s[1]), 32'd0);
    check("post-rst rdata",      resp_rdata_s[1],      32'd0);
    check("post-rst err",        32'(resp_err_s[1]),   32'd0);

    txn(1, 1'b1, 32'hFC, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 1'b0, "last word store");
    for (int i = 0; i < 14; i++)
      txn(1, v[i].we, v[i].addr, v[i].wdata, v[i].be, v[i].rd, v[i].err, $sformatf("vec%0d", i));

    // Backpressure: hold the response, and try a store that must be ignored.
    @(negedge clk);
    req_valid_s[1] = 1'b1; req_we_s[1] = 1'b0; req_addr_s[1] = 32'h10; resp_ready_s[1] = 1'b0;
    @(posedge clk); #1;
    req_valid_s[1] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp_valid_s[1]) break;
    end
    check("bp latency", 32'(lat), 32'd3);
    req_valid_s[1] = 1'b1; req_we_s[1] = 1'b1; req_wdata_s[1] = 32'h0; req_be_s[1] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp resp_valid", 32'(resp_valid_s[1]), 32'd1);
      check("bp rdata",      resp_rdata_s[1],      32'hDEADBEEF);
      check("bp req_ready",  32'(req_ready_s[1]),  32'd0);
    end
    req_valid_s[1] = 1'b0; resp_ready_s[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp release resp_valid", 32'(resp_valid_s[1]), 32'd0);
    check("bp release req_ready",  32'(req_ready_s[1]),  32'd1);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "bp ignored store");

    // Reset during the first WAIT cycle drops the store.
    txn(1, 1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, "zero 0x30");
    @(negedge clk);
    req_valid_s[1] = 1'b1; req_we_s[1] = 1'b1; req_addr_s[1] = 32'h30;
    req_wdata_s[1] = 32'h12345678; req_be_s[1] = 4'hF;
    @(posedge clk); #1;
    req_valid_s[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midwait rst req_ready",  32'(req_ready_s[1]),  32'd1);
    check("midwait rst resp_valid", 32'(resp_valid_s[1]), 32'd0);
    check("midwait rst rdata",      resp_rdata_s[1],      32'd0);
    txn(1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, "midwait load 0x30");

    // WAIT_CYCLES = 0: preload, then four loads with req_valid held high.
    exp0[0] = 32'h01010101; exp0[1] = 32'h20202020; exp0[2] = 32'h3C3C3C3C; exp0[3] = 32'h4D4D4D4D;
    for (int i = 0; i < 4; i++)
      txn(0, 1'b1, 32'(4*i), exp0[i], 4'hF, exp0[i], 1'b0, $sformatf("w0 preload%0d", i));
    @(negedge clk);
    req_valid_s[0] = 1'b1; req_we_s[0] = 1'b0; req_addr_s[0] = 32'h0; resp_ready_s[0] = 1'b1;
    k = 0; nresp = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (resp_valid_s[0] && nresp < 4) begin
        check($sformatf("w0 b2b rdata%0d", nresp), resp_rdata_s[0], exp0[nresp]);
        resp_cyc[nresp] = cyc;
        nresp++;
      end
      was_ready = req_ready_s[0];
      @(posedge clk); #1;
      if (was_ready && req_valid_s[0]) begin
        k++;
        if (k < 4) req_addr_s[0] = 32'(4*k);
        else req_valid_s[0] = 1'b0;
      end
    end
    check("w0 b2b response count", 32'(nresp), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < nresp) check($sformatf("w0 b2b resp cycle%0d", i), 32'(resp_cyc[i]), 32'(2*i + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
